// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
// Module  : accum_pkg
// Purpose : Shared types and helpers for the multi-lane FP32 accumulator.
//           Provides the FP32 word type, the +0.0 constant, the control
//           state encoding and a single-precision add used by the lane IP.
// Revision: 1.0 - initial release
// ============================================================================
package accum_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_ZERO = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } accum_state_e;

  // IEEE-754 single add, round-to-nearest-even. Subnormal operands and
  // results flush to zero; an Inf/NaN operand with the larger magnitude is
  // passed through unchanged.
  function automatic fp32_t fp_add(input fp32_t a_in, input fp32_t b_in);
    fp32_t              a, b, t, res;
    logic [26:0]        ma, mb, mbs, m;
    logic [27:0]        sum;
    logic [24:0]        rnd;
    logic [7:0]         d;
    logic signed [9:0]  e;
    logic [4:0]         lz;
    logic               sticky, rup;
    a      = (a_in[30:23] == 8'd0) ? {a_in[31], 31'd0} : a_in;
    b      = (b_in[30:23] == 8'd0) ? {b_in[31], 31'd0} : b_in;
    sticky = 1'b0;
    lz     = 5'd0;
    m      = 27'd0;
    // Order operands so that |a| >= |b|; the result takes a's sign.
    if (a[30:0] < b[30:0]) begin
      t = a;
      a = b;
      b = t;
    end
    res = a;
    if (b[30:23] != 8'd0 && a[30:23] != 8'hFF) begin
      // 27-bit mantissa: hidden bit, 23 fraction bits, guard/round/sticky.
      ma = {1'b1, a[22:0], 3'b000};
      mb = {1'b1, b[22:0], 3'b000};
      d  = a[30:23] - b[30:23];
      if (d > 8'd26) begin
        mbs = 27'd1;
      end else begin
        sticky = |(mb & ((27'd1 << d) - 27'd1));
        mbs    = (mb >> d) | {26'd0, sticky};
      end
      e = $signed({2'b00, a[30:23]});
      if (a[31] == b[31]) begin
        sum = {1'b0, ma} + {1'b0, mbs};
        if (sum[27]) begin
          m = sum[27:1] | {26'd0, sum[0]};
          e = e + 10'sd1;
        end else begin
          m = sum[26:0];
        end
      end else begin
        m  = ma - mbs;
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
          if (m[i]) lz = 5'(26 - i);
        end
        m = m << lz;
        e = e - $signed({5'd0, lz});
      end
      if (m == 27'd0) begin
        res = FP32_ZERO;
      end else begin
        rup = m[2] & (m[1] | m[0] | m[3]);
        rnd = {1'b0, m[26:3]} + {24'd0, rup};
        if (rnd[24]) begin
          rnd = rnd >> 1;
          e   = e + 10'sd1;
        end
        if (e <= 10'sd0)
          res = {a[31], 31'd0};
        else if (e >= 10'sd255)
          res = {a[31], 8'hFF, 23'd0};
        else
          res = {a[31], e[7:0], rnd[22:0]};
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/FP32_accum.sv
`default_nettype none
// ============================================================================
// Module  : FP32_accum
// Purpose : Single-lane FP32 accumulator. On each enabled cycle the running
//           sum is reloaded with i_x when i_n is high, otherwise i_x is added
//           to it. The sum reaches o_r LAT enabled cycles after the beat that
//           produced it; with i_en low the whole lane holds.
// Ports   : clk      - clock
//           i_areset - asynchronous active-high reset
//           i_en     - advance the accumulator and its output pipeline
//           i_x      - FP32 operand
//           i_n      - start a new sum with this operand
//           o_r      - delayed running sum
// Revision: 1.0 - initial release
// ============================================================================
module FP32_accum
  import accum_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic  clk,
  input  logic  i_areset,
  input  logic  i_en,
  input  fp32_t i_x,
  input  logic  i_n,
  output fp32_t o_r
);

  fp32_t r_acc;
  fp32_t r_pipe [LAT];

  always_ff @(posedge clk or posedge i_areset) begin
    if (i_areset) begin
      r_acc <= FP32_ZERO;
      for (int i = 0; i < LAT; i++) r_pipe[i] <= FP32_ZERO;
    end else if (i_en) begin
      r_acc     <= i_n ? i_x : fp_add(r_acc, i_x);
      r_pipe[0] <= r_acc;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_r = r_pipe[LAT-1];

endmodule
`default_nettype wire

// File: rtl/accum_vec.sv
`default_nettype none
// ============================================================================
// Module  : accum_vec
// Purpose : Multi-lane FP32 dot-product accumulator. Accepts cfg_len beats of
//           LANES-wide FP32 vectors, accumulates each lane in its own
//           FP32_accum, flushes the lane pipelines with +0.0 and presents the
//           registered per-lane sums on a valid/ready output.
// Ports   : clk, rst_n          - clock, async active-low reset
//           clr                 - synchronous abort (also resets lane IPs)
//           start, cfg_len      - begin a set of cfg_len beats (IDLE only)
//           in_valid/in_ready   - input beat handshake, data_in lanes packed
//           out_valid/out_ready - result handshake, data_out lanes packed
//           busy                - any state other than IDLE
// Revision: 1.0 - initial release
// ============================================================================
module accum_vec
  import accum_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LAT   = 3,
  parameter int LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  start,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*32-1:0]   data_out,
  output logic                  busy
);

  localparam int DW = $clog2(LAT + 1);

  accum_state_e          r_state;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_beat_cnt;
  logic [DW-1:0]         r_drain_cnt;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_busy;
  logic [LANES*32-1:0]   r_data_out;

  logic                  w_ip_areset;
  logic                  w_accept;
  logic                  w_drain_en;
  logic                  w_ip_en;
  logic                  w_ip_n;
  fp32_t                 w_ip_r [LANES];

  // r_in_ready is only ever set while in ACCUM, so it doubles as the
  // state qualifier for the input handshake.
  assign w_ip_areset = !rst_n || clr;
  assign w_accept    = in_valid && r_in_ready;
  // The drain phase lasts LAT+1 cycles: LAT enabled cycles push the last
  // sum to the IP output, the final cycle only captures it.
  assign w_drain_en  = (r_state == DRAIN) && (r_drain_cnt != DW'(LAT));
  assign w_ip_en     = w_accept || w_drain_en;
  assign w_ip_n      = w_accept && (r_beat_cnt == '0);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp32_t w_x;
    assign w_x = w_accept ? data_in[32*g +: 32] : FP32_ZERO;

    FP32_accum #(
      .LAT (LAT)
    ) u_fp32_accum (
      .clk      (clk),
      .i_areset (w_ip_areset),
      .i_en     (w_ip_en),
      .i_x      (w_x),
      .i_n      (w_ip_n),
      .o_r      (w_ip_r[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_data_out  <= '0;
    end else if (clr) begin
      // Abort wins over everything, including a coincident start;
      // the last result stays visible on data_out.
      r_state     <= IDLE;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (cfg_len != '0) begin
              r_len      <= cfg_len;
              r_beat_cnt <= '0;
              r_in_ready <= 1'b1;
              r_state    <= ACCUM;
            end else begin
              r_data_out  <= '0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            // Compare against len-1 so a full-scale len never wraps.
            if (r_beat_cnt == r_len - 1'b1) begin
              r_beat_cnt  <= '0;
              r_drain_cnt <= '0;
              r_in_ready  <= 1'b0;
              r_state     <= DRAIN;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (r_drain_cnt == DW'(LAT)) begin
            for (int i = 0; i < LANES; i++) r_data_out[32*i +: 32] <= w_ip_r[i];
            r_drain_cnt <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign data_out  = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_accum_vec.sv
`default_nettype none
// ============================================================================
// Module  : tb_accum_vec
// Purpose : Directed self-checking bench for accum_vec (2 lanes, LAT=3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_accum_vec;

  localparam int LANES = 2;
  localparam int LAT   = 3;
  localparam int LEN_W = 16;

  localparam logic [31:0] F1  = 32'h3F800000;
  localparam logic [31:0] F2  = 32'h40000000;
  localparam logic [31:0] F3  = 32'h40400000;
  localparam logic [31:0] F4  = 32'h40800000;
  localparam logic [31:0] F6  = 32'h40C00000;
  localparam logic [31:0] F10 = 32'h41200000;

  logic                 clk;
  logic                 rst_n;
  logic                 clr;
  logic                 start;
  logic [LEN_W-1:0]     cfg_len;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*32-1:0]  data_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*32-1:0]  data_out;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  accum_vec #(
    .LANES (LANES),
    .LAT   (LAT),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .start     (start),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_set(input logic [LEN_W-1:0] len);
    start   = 1'b1;
    cfg_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d);
    data_in  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges from the current point until out_valid rises (bounded).
  task automatic wait_result(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(exp_lat));
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check(tag, {62'd0, out_valid, busy}, 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    logic [5:0]  pat;
    logic [63:0] beats [3];
    int          k;

    rst_n = 1'b0; clr = 1'b0; start = 1'b0; cfg_len = '0;
    in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    tick(); tick();
    check("reset_ctrl", {61'd0, in_ready, out_valid, busy}, 64'd0);
    check("reset_data", data_out, 64'd0);
    rst_n = 1'b1;
    tick();

    // Set 1: 1+2+3 on lane0, 2+2+2 on lane1.
    start_set(16'd3);
    check("s1_start", {62'd0, in_ready, busy}, 64'd3);
    send_beat({F2, F1});
    send_beat({F2, F2});
    send_beat({F2, F3});
    check("s1_drain_ready", {63'd0, in_ready}, 64'd0);
    wait_result("s1_latency", LAT + 1);
    check("s1_sum", data_out, {F6, F6});
    pop("s1_pop");

    // Set 2: same beats with bubbles, valid pattern 1,0,0,1,0,1.
    beats[0] = {F2, F1}; beats[1] = {F2, F2}; beats[2] = {F2, F3};
    pat = 6'b101001;
    k = 0;
    start_set(16'd3);
    for (int c = 0; c < 6; c++) begin
      in_valid = pat[c];
      data_in  = pat[c] ? beats[k] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (pat[c]) k++;
      tick();
      if (c == 2) check("s2_bubble_ready", {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    wait_result("s2_latency", LAT + 1);
    check("s2_sum", data_out, {F6, F6});
    pop("s2_pop");

    // Set 3: back-to-back, result held while out_ready stays low.
    start_set(16'd3);
    send_beat({F2, F1});
    send_beat({F2, F2});
    send_beat({F2, F3});
    wait_result("s3_latency", LAT + 1);
    held = data_out;
    check("s3_sum", held, {F6, F6});
    for (int c = 0; c < 5; c++) begin
      start   = 1'b1;
      cfg_len = 16'd1;
      tick();
    end
    start = 1'b0;
    check("s3_hold_data", data_out, held);
    check("s3_hold_ctrl", {61'd0, in_ready, out_valid, busy}, 64'd3);
    pop("s3_pop");
    start_set(16'd1);
    send_beat({F4, F4});
    wait_result("s4_latency", LAT + 1);
    check("s4_sum", data_out, {F4, F4});
    pop("s4_pop");

    // Abort mid-ACCUM after 2 of 4 beats, with a coincident start.
    start_set(16'd4);
    send_beat({F1, F1});
    send_beat({F2, F2});
    clr     = 1'b1;
    start   = 1'b1;
    cfg_len = 16'd4;
    tick();
    clr   = 1'b0;
    start = 1'b0;
    check("clr_ctrl", {61'd0, in_ready, out_valid, busy}, 64'd0);
    check("clr_data_kept", data_out, {F4, F4});
    tick();
    check("clr_start_dropped", {63'd0, busy}, 64'd0);
    start_set(16'd4);
    send_beat({F1, F1});
    send_beat({F2, F2});
    send_beat({F3, F3});
    send_beat({F4, F4});
    wait_result("clr_latency", LAT + 1);
    check("clr_sum", data_out, {F10, F10});
    pop("clr_pop");

    // Zero-length set.
    start_set(16'd0);
    check("len0_valid", {62'd0, out_valid, in_ready}, 64'd2);
    check("len0_data", data_out, 64'd0);
    pop("len0_pop");

    // start during DRAIN and in_valid during DONE are ignored.
    start_set(16'd1);
    send_beat({F2, F2});
    start   = 1'b1;
    cfg_len = 16'd5;
    tick();
    start = 1'b0;
    check("drain_start_ready", {62'd0, in_ready, busy}, 64'd1);
    wait_result("drain_latency", LAT);
    in_valid = 1'b1;
    data_in  = {F4, F4};
    tick(); tick();
    in_valid = 1'b0;
    check("done_in_ready", {62'd0, in_ready, out_valid}, 64'd1);
    check("done_data", data_out, {F2, F2});
    pop("done_pop");
    tick();
    check("done_no_restart", {63'd0, busy}, 64'd0);

    // Asynchronous reset in the middle of DRAIN.
    start_set(16'd1);
    send_beat({F3, F3});
    tick();
    check("arst_pre_busy", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", {61'd0, in_ready, out_valid, busy}, 64'd0);
    check("arst_data", data_out, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_set(16'd1);
    send_beat({F1, F1});
    wait_result("arst_latency", LAT + 1);
    check("arst_recover_sum", data_out, {F1, F1});
    pop("arst_pop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
